// File: rtl/slice_result_collector.sv
// Buffers one 64-line frame of 25-bit slice results, then drains it in line order
// over a valid/ready stream. Define PARITY_EN to build the registered out_parity bit.
module slice_result_collector #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_parity,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] slice_mem [DEPTH];

  logic wr_en, load, accept;

  // start overrides everything else in the cycle it is seen
  assign wr_en  = (state == COLLECT) && res_valid && !start;
  assign load   = (state == DRAIN) && !out_valid && !start;
  assign accept = (state == DRAIN) && out_valid && out_ready && !start;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (res_valid && wr_ptr == LAST) state_next = DRAIN;
        DRAIN:   if (out_valid && out_ready && rd_ptr == LAST) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) slice_mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        out_valid <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (res_valid && state != COLLECT) overflow <= 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        // One entry every two cycles: present, accept, then fetch the next
        if (load) begin
          out_valid <= 1'b1;
          out_data  <= slice_mem[rd_ptr];
          out_index <= rd_ptr;
        end
        if (accept) begin
          out_valid <= 1'b0;
          rd_ptr    <= rd_ptr + 1'b1;
          if (rd_ptr == LAST) frame_done <= 1'b1;
        end
      end
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_parity <= 1'b0;
    else if (load) out_parity <= ^slice_mem[rd_ptr];
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_slice_result_collector.sv
// Scoreboard bench for slice_result_collector: a frame-level model queues expected
// entries, and a negedge monitor checks every accepted entry and per-cycle timing.
module tb_slice_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        res_valid = 1'b0;
  logic [24:0] res_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_data;
  logic [5:0]  out_index;
  logic        out_parity;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  slice_result_collector dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_parity(out_parity), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [24:0] data;
  } entry_t;

  entry_t      exp_q[$];
  logic [24:0] frame_q[$];
  int          phase = 0;
  logic        model_ovf = 1'b0;
  int          ready_mode = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        fd_pending = 1'b0;
  logic        gap_pending = 1'b0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_index = '0;
  logic [24:0] prev_data = '0;

  function automatic logic exp_parity(input logic [24:0] d);
`ifdef PARITY_EN
    return ^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    frame_q.delete();
    phase = 0;
    model_ovf = 1'b0;
  endtask

  task automatic checkReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_index", out_index, 0);
    checkOutput("rst_out_parity", out_parity, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_overflow", overflow, 0);
  endtask

  // Drives one cycle of inputs and advances the frame-level model
  task automatic applyStimulus(input logic s, input logic v, input logic [24:0] d);
    start = s;
    res_valid = v;
    res_data = d;
    if (s) begin
      frame_q.delete();
      phase = 1;
      model_ovf = 1'b0;
    end else if (v) begin
      if (phase == 1) begin
        frame_q.push_back(d);
        if (frame_q.size() == 64) begin
          for (int i = 0; i < 64; i++) exp_q.push_back('{idx: 6'(i), data: frame_q[i]});
          frame_q.delete();
          phase = 2;
        end
      end else begin
        model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    res_valid = 1'b0;
    checkOutput("overflow", overflow, model_ovf);
    checkOutput("busy", busy, phase != 0);
  endtask

  task automatic writeFrame(input int mode, input logic [24:0] k);
    logic [24:0] d;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, '0);
      d = (mode == 0) ? 25'(i) + k : (mode == 1) ? k : 25'($urandom());
      applyStimulus(1'b0, 1'b1, d);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || phase != 0) && n < budget) begin
      applyStimulus(1'b0, 1'b0, '0);
      n++;
    end
    checkOutput("drain_timeout", (exp_q.size() != 0 || phase != 0), 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and checks stall/gap/done timing
  always @(negedge clk) begin
    entry_t e;
    if (rst) begin
      fd_pending = 1'b0;
      gap_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checkOutput("frame_done", frame_done, fd_pending);
      fd_pending = 1'b0;
      if (gap_pending) checkOutput("gap_out_valid", out_valid, 0);
      gap_pending = 1'b0;
      if (prev_stall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_index", out_index, prev_index);
        checkOutput("hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready && !start;
      prev_index = out_index;
      prev_data = out_data;
      if (out_valid && out_ready && !start) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_entry", out_index, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_index", out_index, e.idx);
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_parity", out_parity, exp_parity(e.data));
          if (e.idx == 6'd63) begin
            fd_pending = 1'b1;
            phase = 0;
          end
        end
        gap_pending = 1'b1;
      end
    end
  end

  initial begin
    clearModel();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] ramp frame, ready held high");
    ready_mode = 1;
    applyStimulus(1'b1, 1'b0, '0);
    writeFrame(0, 25'd0);
    waitDrain(2000);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] all-ones frame with 10-cycle stall");
    ready_mode = 0;
    applyStimulus(1'b1, 1'b0, '0);
    writeFrame(1, 25'h1FFFFFF);
    repeat (10) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_valid", out_valid, 1);
    checkOutput("stall_index", out_index, 0);
    checkOutput("stall_data", out_data, 25'h1FFFFFF);
    ready_mode = 1;
    waitDrain(2000);

    $display("[TB] abort after 30 writes");
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 25'($urandom()));
    applyStimulus(1'b1, 1'b0, '0);
    writeFrame(1, 25'h0AAAAAA);
    waitDrain(2000);

    $display("[TB] overflow in IDLE and DRAIN");
    applyStimulus(1'b0, 1'b1, 25'h155);
    checkOutput("ovf_idle", overflow, 1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("ovf_cleared", overflow, 0);
    ready_mode = 0;
    writeFrame(2, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 25'h1234567);
    checkOutput("ovf_drain", overflow, 1);
    ready_mode = 2;
    waitDrain(4000);
    applyStimulus(1'b1, 1'b1, 25'h0DEAD);
    checkOutput("ovf_start_clear", overflow, 0);

    $display("[TB] start with simultaneous res_valid");
    writeFrame(0, 25'd100);
    waitDrain(4000);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 1'b0, '0);
      writeFrame(2, '0);
      waitDrain(4000);
    end

    $display("[TB] parity frame then reset mid-drain");
    ready_mode = 0;
    applyStimulus(1'b1, 1'b0, '0);
    writeFrame(1, 25'h0000007);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("par_valid", out_valid, 1);
    checkOutput("par_data", out_data, 25'h0000007);
    checkOutput("par_parity", out_parity, exp_parity(25'h0000007));
    rst = 1'b1;
    clearModel();
    #1;
    checkReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    checkReset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
